// File: rtl/layer0_input_quantizer.sv
// layer0_input_quantizer
//   Front end of the classifier pipeline. Each accepted signed sample is
//   quantized to a 2-bit code using three fixed thresholds. A complete frame
//   of NUM_FEATURES codes is packed into one flat vector and presented on a
//   registered valid/ready output. Frames that are too short or too long
//   are rejected.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous active-high reset
//   s_valid    input beat valid
//   s_ready    input beat accepted when s_valid & s_ready
//   s_data     signed feature sample
//   s_last     last beat of a frame
//   m_valid    packed frame valid
//   m_ready    downstream accepts when m_valid & m_ready
//   m_data     packed codes, feature i at bits [2i+1:2i]
//   err        one-cycle pulse per rejected frame
//   err_count  saturating count of rejected frames
module layer0_input_quantizer #(
    parameter int                        NUM_FEATURES = 16,
    parameter int                        FEAT_W       = 16,
    parameter logic signed [FEAT_W-1:0]  T0           = -64,
    parameter logic signed [FEAT_W-1:0]  T1           = 0,
    parameter logic signed [FEAT_W-1:0]  T2           = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [FEAT_W-1:0]             s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*NUM_FEATURES-1:0]     m_data,
    output logic                          err,
    output logic [15:0]                   err_count
);

    localparam int               IDX_W    = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic {
        FILL    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg;
    logic                        pending_reg;
    logic [2*NUM_FEATURES-1:0]   acc_reg, acc_next;
    logic [2*NUM_FEATURES-1:0]   m_data_reg;
    logic                        m_valid_reg;
    logic                        err_reg;
    logic [15:0]                 err_count_reg;

    logic signed [FEAT_W-1:0]    sample;
    logic [1:0]                  code;
    logic                        beat_fire;
    logic                        at_last_idx;
    logic                        fill_beat, good_frame, short_frame, long_frame, discard_end;

    // Beat handshake is derived from state directly rather than from s_ready
    // so the decode block below has no combinational feedback.
    assign beat_fire   = s_valid && !rst && !pending_reg;
    assign at_last_idx = (idx_reg == LAST_IDX);
    assign sample      = $signed(s_data);

    // Threshold quantizer: both operands are signed, so the compares are signed.
    always_comb begin
        if (sample < T0)
            code = 2'd0;
        else if (sample < T1)
            code = 2'd1;
        else if (sample < T2)
            code = 2'd2;
        else
            code = 2'd3;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= FILL;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                if (beat_fire && at_last_idx && !s_last)
                    state_next = DISCARD;
            end
            DISCARD: begin
                if (beat_fire && s_last)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Output / action decode.
    always_comb begin
        s_ready     = !rst && !pending_reg;
        fill_beat   = 1'b0;
        good_frame  = 1'b0;
        short_frame = 1'b0;
        long_frame  = 1'b0;
        discard_end = 1'b0;
        case (state_reg)
            FILL: begin
                if (beat_fire) begin
                    fill_beat = 1'b1;
                    if (at_last_idx) begin
                        if (s_last)
                            good_frame = 1'b1;
                        else
                            long_frame = 1'b1;
                    end else if (s_last) begin
                        short_frame = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (beat_fire && s_last)
                    discard_end = 1'b1;
            end
            default: ;
        endcase
    end

    // Per-lane code write: only the lane addressed by idx takes the new code.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FEATURES; gi++) begin : g_lane
            assign acc_next[2*gi +: 2] = (fill_beat && (idx_reg == IDX_W'(gi)))
                                         ? code : acc_reg[2*gi +: 2];
        end
    endgenerate

    // Datapath: accumulator, index, pending slot, output register, errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            pending_reg   <= 1'b0;
            acc_reg       <= '0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            err_reg <= short_frame || long_frame;

            if ((short_frame || long_frame) && (err_count_reg != 16'hFFFF))
                err_count_reg <= err_count_reg + 16'd1;

            // Index wraps at the end of every frame, good or bad; in DISCARD
            // it already sits at 0 and is simply held there.
            if (fill_beat)
                idx_reg <= (at_last_idx || s_last) ? '0 : idx_reg + IDX_W'(1);
            else if (discard_end)
                idx_reg <= '0;

            // The completed frame stays in acc_reg while pending; s_ready is
            // low then, so nothing can overwrite it before it moves out.
            if (good_frame && (!m_valid_reg || m_ready)) begin
                m_data_reg  <= acc_next;
                m_valid_reg <= 1'b1;
            end else if (good_frame) begin
                pending_reg <= 1'b1;
            end else if (pending_reg && m_ready) begin
                m_data_reg  <= acc_reg;
                m_valid_reg <= 1'b1;
                pending_reg <= 1'b0;
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_layer0_input_quantizer.sv
module tb_layer0_input_quantizer;

    localparam int NF = 3;
    localparam int FW = 16;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [FW-1:0]     s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [2*NF-1:0]   m_data;
    logic              err;
    logic [15:0]       err_count;

    int n_checks = 0;
    int n_fail   = 0;

    layer0_input_quantizer #(
        .NUM_FEATURES(NF),
        .FEAT_W(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .err(err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [FW-1:0] d0;
        logic signed [FW-1:0] d1;
        logic signed [FW-1:0] d2;
        logic [2*NF-1:0]      exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [FW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Hand-computed codes: bits [1:0]=feature0, [3:2]=feature1, [5:4]=feature2.
        vecs[0] = '{d0: -16'sd100,   d1: 16'sd0,      d2: 16'sd64,   exp_data: 6'b111000};
        vecs[1] = '{d0: -16'sd65,    d1: -16'sd64,    d2: 16'sd63,   exp_data: 6'b100100};
        vecs[2] = '{d0: 16'sd32767,  d1: -16'sd32768, d2: -16'sd1,   exp_data: 6'b010011};
        vecs[3] = '{d0: 16'sd63,     d1: 16'sd64,     d2: -16'sd63,  exp_data: 6'b011110};
        vecs[4] = '{d0: 16'sd0,      d1: -16'sd1,     d2: -16'sd64,  exp_data: 6'b010110};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        chk("reset_m_data", {26'd0, m_data}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_s_ready", {31'd0, s_ready}, 32'd1);

        // Back-to-back frames with m_ready held high.
        for (int i = 0; i < 5; i++) begin
            beat(vecs[i].d0, 1'b0);
            beat(vecs[i].d1, 1'b0);
            beat(vecs[i].d2, 1'b1);
            chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, 32'd1);
            chk($sformatf("vec%0d_m_data", i), {26'd0, m_data}, {26'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
            $display("vector %0d: m_valid=%0b m_data=%b expected=%b", i, m_valid, m_data, vecs[i].exp_data);
        end
        idle();
        chk("drain_m_valid", {31'd0, m_valid}, 32'd0);

        // Short frame: two beats, last on the second.
        beat(16'sd10, 1'b0);
        beat(16'sd20, 1'b1);
        chk("short_err", {31'd0, err}, 32'd1);
        chk("short_err_count", {16'd0, err_count}, 32'd1);
        chk("short_m_valid", {31'd0, m_valid}, 32'd0);
        idle();
        chk("short_err_pulse_end", {31'd0, err}, 32'd0);
        chk("short_no_m_valid", {31'd0, m_valid}, 32'd0);
        beat(-16'sd100, 1'b0);
        beat(16'sd0, 1'b0);
        beat(16'sd64, 1'b1);
        chk("after_short_m_valid", {31'd0, m_valid}, 32'd1);
        chk("after_short_m_data", {26'd0, m_data}, {26'd0, 6'b111000});
        $display("short frame: err_count=%0d m_data=%b", err_count, m_data);

        // Fresh reset before the long-frame case.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        #1;
        chk("rst2_err_count", {16'd0, err_count}, 32'd0);

        // Long frame: five beats, last only on the fifth.
        beat(16'sd1, 1'b0);
        beat(16'sd2, 1'b0);
        beat(16'sd3, 1'b0);
        chk("long_err_beat3", {31'd0, err}, 32'd1);
        chk("long_m_valid_beat3", {31'd0, m_valid}, 32'd0);
        beat(16'sd4, 1'b0);
        chk("long_err_beat4", {31'd0, err}, 32'd0);
        chk("long_s_ready_discard", {31'd0, s_ready}, 32'd1);
        beat(16'sd5, 1'b1);
        chk("long_err_beat5", {31'd0, err}, 32'd0);
        chk("long_m_valid_beat5", {31'd0, m_valid}, 32'd0);
        chk("long_err_count", {16'd0, err_count}, 32'd1);
        idle();
        chk("long_no_m_valid", {31'd0, m_valid}, 32'd0);
        chk("long_no_err", {31'd0, err}, 32'd0);
        beat(16'sd63, 1'b0);
        beat(16'sd64, 1'b0);
        beat(-16'sd63, 1'b1);
        chk("after_long_m_valid", {31'd0, m_valid}, 32'd1);
        chk("after_long_m_data", {26'd0, m_data}, {26'd0, 6'b011110});
        $display("long frame: err_count=%0d m_data=%b", err_count, m_data);
        idle();

        // Backpressure: A delivered and held, B completes into pending.
        m_ready = 1'b0;
        beat(-16'sd100, 1'b0);
        beat(16'sd0, 1'b0);
        beat(16'sd64, 1'b1);
        chk("bp_a_m_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_a_m_data", {26'd0, m_data}, {26'd0, 6'b111000});
        chk("bp_a_s_ready", {31'd0, s_ready}, 32'd1);
        beat(-16'sd65, 1'b0);
        beat(-16'sd64, 1'b0);
        beat(16'sd63, 1'b1);
        chk("bp_b_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_b_m_data_held", {26'd0, m_data}, {26'd0, 6'b111000});
        chk("bp_b_m_valid", {31'd0, m_valid}, 32'd1);
        // A beat offered while pending must not be consumed.
        s_valid = 1'b1;
        s_data  = 16'sd500;
        s_last  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("bp_hold_m_data", {26'd0, m_data}, {26'd0, 6'b111000});
        chk("bp_hold_s_ready", {31'd0, s_ready}, 32'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_swap_m_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_swap_m_data", {26'd0, m_data}, {26'd0, 6'b100100});
        chk("bp_swap_s_ready", {31'd0, s_ready}, 32'd1);
        idle();
        chk("bp_b_held", {26'd0, m_data}, {26'd0, 6'b100100});
        m_ready = 1'b1;
        idle();
        chk("bp_drained_m_valid", {31'd0, m_valid}, 32'd0);
        $display("backpressure: m_data=%b s_ready=%0b", m_data, s_ready);

        // Reset in the middle of a frame.
        beat(16'sd100, 1'b0);
        beat(16'sd100, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready_during", {31'd0, s_ready}, 32'd0);
        tick();
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_m_data", {26'd0, m_data}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_err_count", {16'd0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_s_ready_after", {31'd0, s_ready}, 32'd1);
        beat(16'sd63, 1'b0);
        chk("midrst_no_early_frame1", {31'd0, m_valid}, 32'd0);
        beat(16'sd64, 1'b0);
        chk("midrst_no_early_frame2", {31'd0, m_valid}, 32'd0);
        beat(-16'sd63, 1'b1);
        chk("midrst_frame_m_valid", {31'd0, m_valid}, 32'd1);
        chk("midrst_frame_m_data", {26'd0, m_data}, {26'd0, 6'b011110});
        chk("midrst_frame_err", {31'd0, err}, 32'd0);
        $display("mid-frame reset: m_data=%b", m_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer0_input_quantizer.md
# layer0_input_quantizer

Front-end stage of the classifier pipeline, directly upstream of the first LUT layer. Accepts one signed feature sample per beat over a valid/ready stream and quantizes each to a 2-bit code with three fixed thresholds. Packs a complete frame of NUM_FEATURES codes into the flat input vector consumed by the layer-0 neurons. Presents that vector through a registered valid/ready output and rejects malformed frames.

## Interface
- NUM_FEATURES, 16: features per frame (≥2).
- FEAT_W, 16: signed feature width.
- T0, -64: lower threshold (signed, FEAT_W bits).
- T1, 0: middle threshold (T0 < T1 < T2 required).
- T2, 64: upper threshold.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  FEAT_W  signed feature sample.
- s_last  in  1  marks the last beat of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.
- m_data  out  2*NUM_FEATURES  packed codes; feature i at bits [2i+1:2i].
- err  out  1  one-cycle pulse per rejected frame.
- err_count  out  16  saturating count of rejected frames.

## Operation
- Code per beat, signed compare: x<T0 → 0; T0≤x<T1 → 1; T1≤x<T2 → 2; x≥T2 → 3.
- Accumulator: index idx (0..NUM_FEATURES-1), code register, `pending` flag. The output register holds m_data/m_valid.
- State FILL:
  - An accepted beat writes its code at idx.
  - If idx==NUM_FEATURES-1 and s_last: frame good. It moves to the output register if the output is empty or accepted this cycle; otherwise set pending. idx returns to 0.
  - If s_last with idx<NUM_FEATURES-1 (short frame): discard the partial frame, idx returns to 0, pulse err, stay in FILL.
  - If idx==NUM_FEATURES-1 without s_last (long frame): the frame is not delivered; pulse err and go to DISCARD.
- State DISCARD: s_ready=1; drop beats until an accepted beat has s_last, then idx returns to 0 and the state goes to FILL. No further err for the same frame.
- pending: s_ready=0. When the output is accepted, the pending frame loads into the output register in that same cycle and pending clears.
- s_ready = !rst & !pending.
- err_count increments on each err pulse and saturates at 16'hFFFF.
- Reset, any cycle including mid-frame: state FILL, idx 0, pending 0, m_valid 0, m_data 0, err 0, err_count 0. Any partial or pending frame is lost.

## Timing
- m_valid rises the cycle after the accepted good s_last beat.
- m_data is stable while m_valid & !m_ready.
- With m_ready held high, frames stream back-to-back at one beat per cycle with no bubbles. Latency is 1 cycle from the last beat to m_valid.
- Output held, new frame completes: pending=1 and s_ready drops the next cycle.
- On the cycle m_ready is seen, m_valid stays 1 with the pending frame. s_ready returns the cycle after.
- Output accepted with no new frame completing: m_valid falls the next cycle.
- err is asserted the cycle after the offending beat is accepted.
- s_ready is 0 during rst and 1 on the first cycle after.

## Test plan
- NUM_FEATURES=3, beats -100, 0, 64 with last on the third, m_ready=1 → one cycle later m_valid=1, m_data=6'b111000, err=0.
- Boundary codes: beats -65, -64, 63 → codes 0, 1, 2, so m_data=6'b100100. Then beats 32767, -32768, -1 → 6'b010011.
- Short frame: 2 beats with last on the second → err pulses once, err_count=1, no m_valid. The next 3-beat frame is delivered normally.
- Long frame: 5 beats with last only on the fifth → one err pulse after beat 3, beats 4–5 dropped, no m_valid, err_count=1.
- Backpressure with m_ready=0: frame A delivered, frame B completes → s_ready=0, m_data=A held. Raise m_ready for one cycle → m_data=B next cycle with m_valid=1, then s_ready=1.
- Assert rst after beat 2 of a frame → all outputs reset. A following full frame packs correctly from index 0.
